// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM state and register types for axi4_sram_ctrl
package sram_ctrl_pkg;
  import types_amba_pkg::*;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
  // sized for the widest legal data bus; narrower builds use the low slices
  typedef struct packed {
    state_e state;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic write;
    logic [127:0] wdata;
    logic [15:0] wstrb;
    logic err;
    logic [127:0] rdata;
    logic [2:0] cnt;
  } regs_t;
  localparam regs_t REGS_RST = '{state: IDLE, default: '0};
endpackage

// File: rtl/types_amba_pkg.sv
// types_amba_pkg: system bus constants shared across AMBA-attached blocks
package types_amba_pkg;
  localparam int CFG_SYSBUS_ADDR_BITS = 48;
endpackage

// File: rtl/axi4_sram_ctrl_if.sv
// axi4_sram_ctrl_if: request/response channel between axi_slv and the SRAM controller
interface axi4_sram_ctrl_if #(parameter int log2_dbytes = 3);
  logic req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [types_amba_pkg::CFG_SYSBUS_ADDR_BITS-1:0] req_addr;
  logic [(8<<log2_dbytes)-1:0] req_wdata, resp_rdata;
  logic [(1<<log2_dbytes)-1:0] req_wstrb;
  modport master(output req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready,
                 input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave(input req_valid, req_addr, req_write, req_wdata, req_wstrb, resp_ready,
                output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/axi4_sram_ctrl.sv
// axi4_sram_ctrl: single-outstanding request-to-SRAM controller with read wait states and error responses
module axi4_sram_ctrl import sram_ctrl_pkg::*; #(
  parameter int abits = 17,
  parameter int log2_dbytes = 3,
  parameter int rd_latency = 1,
  parameter int readonly = 0
) (
  input  logic i_clk,
  input  logic i_nrst,
  axi4_sram_ctrl_if.slave bus,
  output logic o_mem_cs,
  output logic o_mem_we,
  output logic [abits-log2_dbytes-1:0] o_mem_addr,
  output logic [(1<<log2_dbytes)-1:0] o_mem_wstrb,
  output logic [(8<<log2_dbytes)-1:0] o_mem_wdata,
  input  logic [(8<<log2_dbytes)-1:0] i_mem_rdata
);
  localparam int dw = 8 << log2_dbytes;
  localparam int sw = 1 << log2_dbytes;
  regs_t r_q, r_d;
  logic unused_bits;
  always_comb begin
    r_d = r_q;
    unique case (r_q.state)
      IDLE: if (bus.req_valid) begin
        r_d.addr = bus.req_addr;
        r_d.write = bus.req_write;
        r_d.wdata = 128'(bus.req_wdata);
        r_d.wstrb = 16'(bus.req_wstrb);
        r_d.rdata = '0;
        r_d.err = (bus.req_addr >> abits) != '0 || (readonly != 0 && bus.req_write);
        r_d.state = r_d.err ? RESP : ACCESS;
      end
      ACCESS: begin
        r_d.cnt = 3'(rd_latency - 1);
        r_d.state = (r_q.write || rd_latency == 1) ? RESP : WAIT;
        if (!r_q.write && rd_latency == 1) r_d.rdata = 128'(i_mem_rdata);
      end
      WAIT: begin
        r_d.cnt = r_q.cnt - 3'd1;
        if (r_q.cnt == 3'd1) begin
          r_d.rdata = 128'(i_mem_rdata);
          r_d.state = RESP;
        end
      end
      default: if (bus.resp_ready) r_d = REGS_RST;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) r_q <= REGS_RST;
    else r_q <= r_d;
  assign bus.req_ready = r_q.state == IDLE;
  assign bus.resp_valid = r_q.state == RESP;
  assign bus.resp_rdata = r_q.rdata[dw-1:0];
  assign bus.resp_err = r_q.err;
  assign o_mem_cs = r_q.state == ACCESS;
  assign o_mem_we = o_mem_cs && r_q.write;
  assign o_mem_addr = r_q.addr[abits-1:log2_dbytes];
  assign o_mem_wstrb = r_q.wstrb[sw-1:0];
  assign o_mem_wdata = r_q.wdata[dw-1:0];
  assign unused_bits = ^r_q;
endmodule
